// File: rtl/ray_aabb_cmp_scheduler.sv
// Ray-AABB slab compare scheduler: feeds one shared pipelined FP >= comparator
// one operand pair per cycle and gathers the per-pair results of a job.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   job_valid/job_ready : job handshake; job_a/job_b hold NPAIR packed words
//   cmp_a/cmp_b         : operands to the shared comparator
//   cmp_issue           : cmp_a/cmp_b carry a live pair this cycle
//   cmp_ge              : comparator result, CMP_LAT cycles after issue
//   res_valid/res_ready : result handshake
//   res_ge              : per-pair results, bit i = pair i
//   res_hit             : AND of all res_ge bits
module ray_aabb_cmp_scheduler #(
  parameter int WIDTH   = 20,
  parameter int NPAIR   = 4,
  parameter int CMP_LAT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [NPAIR*(WIDTH+1)-1:0]   job_a,
  input  logic [NPAIR*(WIDTH+1)-1:0]   job_b,
  output logic [WIDTH:0]               cmp_a,
  output logic [WIDTH:0]               cmp_b,
  output logic                         cmp_issue,
  input  logic                         cmp_ge,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [NPAIR-1:0]             res_ge,
  output logic                         res_hit
);

  localparam int W  = WIDTH + 1;
  localparam int IW = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int BW = NPAIR * W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [BW-1:0] opa_q;
  logic [BW-1:0] opa_d;
  logic [BW-1:0] opb_q;
  logic [BW-1:0] opb_d;

  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;

  // Tag pipeline: one stage per comparator latency cycle.
  // Stage CMP_LAT-1 lines up with cmp_ge for the pair it carries.
  logic [CMP_LAT-1:0]         tv_q;
  logic [CMP_LAT-1:0]         tv_d;
  logic [CMP_LAT-1:0][IW-1:0] tt_q;
  logic [CMP_LAT-1:0][IW-1:0] tt_d;

  logic [NPAIR-1:0] ge_q;
  logic [NPAIR-1:0] ge_d;

  logic accept;
  logic push;
  logic last_idx;

  assign job_ready = (state_q == IDLE) && !rst;
  assign cmp_issue = (state_q == ISSUE);
  assign res_valid = (state_q == DONE);
  assign res_ge    = ge_q;
  assign res_hit   = &ge_q;

  assign cmp_a = cmp_issue ? opa_q[int'(idx_q)*W +: W] : '0;
  assign cmp_b = cmp_issue ? opb_q[int'(idx_q)*W +: W] : '0;

  assign accept   = job_valid && job_ready;
  assign push     = cmp_issue;
  assign last_idx = (idx_q == IW'(NPAIR - 1));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    idx_d   = idx_q;
    tv_d    = '0;
    tt_d    = '0;
    ge_d    = ge_q;

    // Shift the tag pipeline every cycle; zeros enter when idle.
    for (int s = CMP_LAT - 1; s > 0; s--) begin
      tv_d[s] = tv_q[s-1];
      tt_d[s] = tt_q[s-1];
    end
    tv_d[0] = push;
    tt_d[0] = push ? idx_q : '0;

    // Only a tagged cycle may touch the result vector, so
    // stale comparator output (NaN, idle) never lands.
    if (tv_q[CMP_LAT-1]) begin
      ge_d[tt_q[CMP_LAT-1]] = cmp_ge;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d   = job_a;
          opb_d   = job_b;
          idx_d   = '0;
          ge_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (last_idx) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        // Leave once the final tag is being retired this
        // cycle, so res_valid follows the last sample.
        if (tv_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      idx_q   <= '0;
      tv_q    <= '0;
      tt_q    <= '0;
      ge_q    <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      idx_q   <= idx_d;
      tv_q    <= tv_d;
      tt_q    <= tt_d;
      ge_q    <= ge_d;
    end
  end

endmodule

// File: tb/tb_ray_aabb_cmp_scheduler.sv
// Bench for ray_aabb_cmp_scheduler: comparator model, scoreboard
// of expected result vectors, directed and random jobs.
module tb_ray_aabb_cmp_scheduler;

  localparam int WIDTH = 20;
  localparam int NP    = 4;
  localparam int LAT   = 3;
  localparam int W     = WIDTH + 1;
  localparam int BW    = NP * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid;
  logic          job_ready;
  logic [BW-1:0] job_a;
  logic [BW-1:0] job_b;
  logic [W-1:0]  cmp_a;
  logic [W-1:0]  cmp_b;
  logic          cmp_issue;
  logic          cmp_ge;
  logic          res_valid;
  logic          res_ready;
  logic [NP-1:0] res_ge;
  logic          res_hit;

  ray_aabb_cmp_scheduler #(
    .WIDTH  (WIDTH),
    .NPAIR  (NP),
    .CMP_LAT(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_a    (job_a),
    .job_b    (job_b),
    .cmp_a    (cmp_a),
    .cmp_b    (cmp_b),
    .cmp_issue(cmp_issue),
    .cmp_ge   (cmp_ge),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_ge   (res_ge),
    .res_hit  (res_hit)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit nan_bit;
  logic [NP-1:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] fp(bit s, int e, int m);
    return {2'b01, s, 11'(e + 1023), 7'(m)};
  endfunction

  // Value of a FloPoCo 11/7 word; infinities as huge reals.
  function automatic real to_real(logic [W-1:0] x);
    real v;
    int  e;
    if (x[W-1:W-2] == 2'b00) return 0.0;
    if (x[W-1:W-2] == 2'b10) return x[W-3] ? -1.0e300 : 1.0e300;
    v = 1.0 + real'(int'(x[6:0])) / 128.0;
    e = int'(x[17:7]) - 1023;
    if (e > 0) repeat (e) v = v * 2.0;
    else repeat (-e) v = v / 2.0;
    return x[W-3] ? -v : v;
  endfunction

  function automatic bit is_nan(logic [W-1:0] x);
    return x[W-1:W-2] == 2'b11;
  endfunction

  function automatic bit fp_ge(logic [W-1:0] a,
                               logic [W-1:0] b, bit nv);
    if (is_nan(a) || is_nan(b)) return nv;
    return to_real(a) >= to_real(b);
  endfunction

  function automatic logic [NP-1:0] ref_vec(logic [BW-1:0] a,
                                            logic [BW-1:0] b,
                                            bit nv);
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++)
      r[i] = fp_ge(a[i*W +: W], b[i*W +: W], nv);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_fp();
    int r;
    logic [W-1:0] x;
    r = $urandom_range(0, 15);
    x = fp(1'($urandom), $urandom_range(0, 16) - 8,
           $urandom_range(0, 127));
    if (r == 0) x[W-1:W-2] = 2'b00;
    else if (r == 1) x[W-1:W-2] = 2'b10;
    else if (r == 2) x[W-1:W-2] = 2'b11;
    return x;
  endfunction

  function automatic logic [BW-1:0] rnd_bus();
    logic [BW-1:0] r;
    for (int i = 0; i < NP; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  // Comparator model: LAT-cycle pipe; untagged cycles give noise.
  bit pv[LAT];
  bit pr[LAT];
  always @(negedge clk) begin
    cmp_ge = pv[LAT-1] ? pr[LAT-1] : 1'($urandom);
    for (int s = LAT - 1; s > 0; s--) begin
      pv[s] = pv[s-1];
      pr[s] = pr[s-1];
    end
    pv[0] = (cmp_issue === 1'b1);
    pr[0] = fp_ge(cmp_a, cmp_b, nan_bit);
  end

  // Result monitor.
  always @(negedge clk) begin
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %b want none", res_ge);
      end else begin
        logic [NP-1:0] e;
        e = sb.pop_front();
        check("res_ge", res_ge, e);
        check("res_hit", res_hit, &e);
      end
    end
  end

  task automatic send_job(input logic [BW-1:0] a,
                          input logic [BW-1:0] b,
                          input bit nv, output int acc);
    @(posedge clk); #1;
    job_a = a;
    job_b = b;
    job_valid = 1'b1;
    nan_bit = nv;
    acc = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (job_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    total++;
    if (acc < 0) begin
      bad++;
      $display("FAIL accept_timeout: got none want accept");
    end else begin
      sb.push_back(ref_vec(a, b, nv));
    end
    @(posedge clk); #1;
    job_valid = 1'b0;
    job_a = rnd_bus();
    job_b = rnd_bus();
  endtask

  task automatic run_job(input logic [BW-1:0] a,
                         input logic [BW-1:0] b,
                         input bit nv, output int acc);
    int lat;
    bit ok;
    send_job(a, b, nv, acc);
    lat = -1;
    ok = 1'b1;
    if (acc >= 0) begin
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (k <= NP) begin
          if (cmp_issue !== 1'b1 ||
              cmp_a !== a[(k-1)*W +: W] ||
              cmp_b !== b[(k-1)*W +: W]) ok = 1'b0;
        end else if (cmp_issue !== 1'b0) begin
          ok = 1'b0;
        end
        if (res_valid === 1'b1) begin
          lat = k;
          break;
        end
      end
      check("latency", lat, NP + LAT + 1);
      check("issue_seq", ok, 1);
    end
  endtask

  function automatic logic [BW-1:0] rnd_job_a();
    logic [BW-1:0] r;
    for (int i = 0; i < NP; i++) r[i*W +: W] = rnd_fp();
    return r;
  endfunction

  function automatic logic [BW-1:0] rnd_job_b(logic [BW-1:0] a);
    logic [BW-1:0] r;
    for (int i = 0; i < NP; i++)
      r[i*W +: W] = ($urandom_range(0, 3) == 0) ?
                    a[i*W +: W] : rnd_fp();
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [NP-1:0] held;
    int acc;
    int acc2;
    bit ok;

    rst = 1'b1;
    job_valid = 1'b0;
    job_a = '0;
    job_b = '0;
    res_ready = 1'b0;
    cmp_ge = 1'b0;
    nan_bit = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_job_ready", job_ready, 0);
    check("rst_cmp_issue", cmp_issue, 0);
    check("rst_cmp_ab", {cmp_a, cmp_b}, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_ge", {res_hit, res_ge}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_job_ready", job_ready, 1);

    // Directed: mixed outcome.
    res_ready = 1'b1;
    a = {fp(1, 0, 0), fp(0, 0, 0), fp(0, 2, 32), fp(0, 1, 0)};
    b = {fp(1, 1, 0), fp(0, 1, 64), fp(0, 2, 32), fp(0, 0, 0)};
    run_job(a, b, 1'b0, acc);
    check("t1_ge", res_ge, 4'b1011);
    check("t1_hit", res_hit, 0);

    // Directed: all pass.
    a = {NP{fp(0, 2, 0)}};
    b = {NP{fp(0, -1, 0)}};
    run_job(a, b, 1'b0, acc);
    check("t2_ge", res_ge, 4'b1111);
    check("t2_hit", res_hit, 1);

    // Backpressure with ignored job_valid pulses.
    @(posedge clk); #1;
    res_ready = 1'b0;
    a = rnd_job_a();
    run_job(a, rnd_job_b(a), 1'b0, acc);
    held = res_ge;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      job_valid = 1'($urandom);
      job_a = rnd_bus();
      job_b = rnd_bus();
      @(negedge clk);
      if (res_valid !== 1'b1 || res_ge !== held ||
          job_ready !== 1'b0) ok = 1'b0;
    end
    check("bp_hold", ok, 1);
    @(posedge clk); #1;
    job_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_idle", {job_ready, res_valid}, 2'b10);

    // Back-to-back: DONE and IDLE cycle follow the 8-cycle job.
    a = rnd_job_a();
    run_job(a, rnd_job_b(a), 1'b1, acc);
    a = rnd_job_a();
    run_job(a, rnd_job_b(a), 1'b0, acc2);
    check("b2b_spacing", acc2 - acc, NP + LAT + 2);

    // Reset in the second ISSUE cycle.
    a = rnd_job_a();
    send_job(a, rnd_job_b(a), 1'b0, acc);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    check("abort_state", {cmp_issue, res_valid, job_ready}, 3'b001);
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (res_valid !== 1'b0) ok = 1'b0;
    end
    check("abort_no_result", ok, 1);
    a = rnd_job_a();
    run_job(a, rnd_job_b(a), 1'b1, acc);

    // NaN pair among ordinary pairs.
    a = {fp(1, 0, 0), {2'b11, 19'h1abcd}, fp(0, 2, 32), fp(0, 1, 0)};
    b = {fp(1, 1, 0), fp(0, 1, 64), fp(0, 2, 32), fp(0, 0, 0)};
    run_job(a, b, 1'($urandom), acc);

    // Random jobs with random result backpressure.
    repeat (30) begin
      @(posedge clk); #1;
      res_ready = 1'b0;
      a = rnd_job_a();
      run_job(a, rnd_job_b(a), 1'($urandom), acc);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      res_ready = 1'b1;
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
